// File: rtl/shift_right_iter.sv
// Iterative right shifter: one bit per clock for logical, arithmetic and rotate modes.
// The result is held until out_ready is seen; data_out is zero in every state except DONE.
module shift_right_iter #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    shift_amt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [AW-1:0]    cnt;
  logic [1:0]       mode_r;
  logic             fill;
  logic             msb;
  logic             accept;

  assign accept = in_valid && (state == IDLE);

  // Bit entering at the top on each shift step; reserved mode 11 behaves as logical.
  always_comb begin
    msb = 1'b0;
    case (mode_r)
      2'b01:   msb = fill;
      2'b10:   msb = work[0];
      default: msb = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (shift_amt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == AW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      mode_r <= 2'b00;
      fill   <= 1'b0;
    end else if (accept) begin
      work   <= data_in;
      cnt    <= shift_amt;
      mode_r <= mode;
      fill   <= data_in[WIDTH-1];
    end else if (state == SHIFT) begin
      work <= {msb, work[WIDTH-1:1]};
      cnt  <= cnt - AW'(1);
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    data_out  = (state == DONE) ? work : '0;
  end

endmodule

// File: tb/tb_shift_right_iter.sv
// Directed vector table, backpressure and reset-abort sequences, then a randomized
// handshake regression scored against a combinational shift model.
module tb_shift_right_iter;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data_in = '0;
  logic [AW-1:0] shift_amt = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  shift_right_iter #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_amt(shift_amt), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [1:0]    m;
    logic [W-1:0]  exp;
    int            stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [AW-1:0] a,
                                         input logic [1:0] m);
    logic [2*W-1:0] dd;
    case (m)
      2'b01:   return W'($signed(d) >>> a);
      2'b10:   begin dd = {d, d} >> a; return dd[W-1:0]; end
      default: return d >> a;
    endcase
  endfunction

  // One full request: accept, shift with garbage on the inputs, optional stall, drain.
  task automatic run_req(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] m,
                         input logic [W-1:0] exp, input int stall, input string tag);
    int n;
    int busy_cnt;
    bit stable;
    @(negedge clk);
    in_valid = 1'b1; data_in = d; shift_amt = a; mode = m;
    chk({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    data_in = ~d; shift_amt = a + 3'd2; mode = m ^ 2'b01;
    n = 0; busy_cnt = 0;
    while (!out_valid && n < 40) begin
      busy_cnt += busy;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk({tag, " latency"}, n, a);
    chk({tag, " data_out"}, data_out, exp);
    chk({tag, " in_ready busy"}, in_ready, 0);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      busy_cnt += busy;
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b1 || data_out !== exp || in_ready !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) chk({tag, " stall stable"}, stable, 1);
    busy_cnt += busy;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drained"}, {out_valid, data_out, in_ready}, {1'b0, 8'h00, 1'b1});
    chk({tag, " busy cycles"}, busy_cnt, a + 1 + stall);
  endtask

  initial begin
    int accepted, drained, cyc;
    logic [W-1:0] q[$];
    bit seen_valid;

    vecs.push_back('{8'b1001_0110, 3'd3, 2'b00, 8'b0001_0010, 0});
    vecs.push_back('{8'b1001_0110, 3'd3, 2'b01, 8'b1111_0010, 0});
    vecs.push_back('{8'b1001_0110, 3'd3, 2'b10, 8'b1101_0010, 0});
    vecs.push_back('{8'hA5, 3'd0, 2'b00, 8'hA5, 0});
    vecs.push_back('{8'hA5, 3'd0, 2'b01, 8'hA5, 2});
    vecs.push_back('{8'hA5, 3'd0, 2'b10, 8'hA5, 0});
    vecs.push_back('{8'hA5, 3'd0, 2'b11, 8'hA5, 0});
    vecs.push_back('{8'h81, 3'd7, 2'b10, 8'h03, 0});
    vecs.push_back('{8'h81, 3'd7, 2'b01, 8'hFF, 0});
    vecs.push_back('{8'h81, 3'd7, 2'b00, 8'h01, 0});
    vecs.push_back('{8'hF0, 3'd2, 2'b11, 8'h3C, 0});
    vecs.push_back('{8'h80, 3'd1, 2'b01, 8'hC0, 0});
    vecs.push_back('{8'h01, 3'd1, 2'b10, 8'h80, 0});
    vecs.push_back('{8'h6C, 3'd4, 2'b01, 8'h06, 5});

    #2;
    chk("reset outputs", {in_ready, out_valid, busy, data_out}, {1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_req(vecs[i].d, vecs[i].a, vecs[i].m, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

    // Abort mid-shift with a half-cycle reset pulse spanning a rising edge.
    @(negedge clk);
    in_valid = 1'b1; data_in = 8'h5A; shift_amt = 3'd5; mode = 2'b00;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort pre busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("abort reset outputs", {in_ready, out_valid, busy, data_out}, {1'b1, 1'b0, 1'b0, 8'h00});
    #4 rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid = 1'b1;
    end
    chk("abort no result", seen_valid, 0);
    run_req(8'hF0, 3'd4, 2'b00, 8'h0F, 0, "post_abort");

    // Random handshake regression against the model.
    accepted = 0; drained = 0; cyc = 0;
    while ((accepted < 1000 || drained < accepted) && cyc < 40000) begin
      @(negedge clk);
      in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      data_in   = W'($urandom);
      shift_amt = AW'($urandom_range(0, W - 1));
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back(model(data_in, shift_amt, mode));
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand duplicate result", 1, 0);
        else chk($sformatf("rand result %0d", drained), data_out, q.pop_front());
        drained++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand accepted", accepted, 1000);
    chk("rand drained", drained, 1000);
    chk("rand queue empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_right_iter.md
SHIFT_RIGHT_ITER -- requirements
Module: shift_right_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (legal values: 4 to 32, power of two).
REQ-002 The block SHALL have derived parameter AW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  request present on data_in/shift_amt/mode.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port data_in  input  WIDTH  operand.
REQ-008 The block SHALL have port shift_amt  input  AW  right-shift distance, 0..WIDTH-1.
REQ-009 The block SHALL have port mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
REQ-010 The block SHALL have port out_valid  output  1  data_out holds a completed result.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 The block SHALL have port data_out  output  WIDTH  shifted result.
REQ-013 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE, and in_ready SHALL equal (state == IDLE).
REQ-015 Accept: on a rising edge with in_valid && in_ready, the block SHALL capture data_in into a working register, capture shift_amt into a down-counter, capture mode, and capture the fill bit (data_in[WIDTH-1]).
REQ-016 After acceptance, the next state SHALL be SHIFT if shift_amt != 0, otherwise DONE.
REQ-017 In SHIFT, each edge SHALL shift the working register right by exactly one bit and decrement the counter by 1.
REQ-018 Logical mode SHALL fill the vacated MSB with 0.
REQ-019 Arithmetic mode SHALL fill the vacated MSB with the captured fill bit.
REQ-020 Rotate mode SHALL move bit 0 into the MSB.
REQ-021 The FSM SHALL leave SHIFT for DONE on the edge where the counter goes from 1 to 0.
REQ-022 Latency: out_valid SHALL rise after exactly shift_amt edges following the accepting edge; shift_amt = 0 therefore gives out_valid on the cycle after acceptance.
REQ-023 In DONE, out_valid SHALL be 1 and data_out SHALL equal the working register, both held stable until out_ready is sampled high.
REQ-024 On an edge in DONE with out_ready = 1, the FSM SHALL return to IDLE and out_valid SHALL drop; a new request can be accepted at the earliest on the following edge (one bubble cycle).
REQ-025 data_out SHALL read 0 in every state other than DONE.
REQ-026 in_valid, data_in, shift_amt and mode SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the result in flight.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 Per request, the result SHALL be bit-exact to a combinational right shift (logical, arithmetic or rotate) of data_in by shift_amt.

Reset
REQ-029 While rst_n = 0, asynchronously and regardless of clk, the state SHALL be IDLE, with in_ready = 1, out_valid = 0, busy = 0, data_out = 0, and the counter and working register = 0.
REQ-030 Reset asserted in SHIFT or DONE SHALL abort the operation and discard its result; after release, the first accepted request SHALL complete normally.
REQ-031 Release of rst_n SHALL NOT require any clock edges before the first request is accepted.

Verification
REQ-032 WIDTH=8, data_in=8'b1001_0110, shift_amt=3, mode=00 -> out_valid 3 edges after accept, data_out=8'b0001_0010; with mode=01 -> 8'b1111_0010; with mode=10 -> 8'b1101_0010.
REQ-033 data_in=8'hA5, shift_amt=0, any mode -> out_valid on the cycle after accept, data_out=8'hA5, busy high for exactly that cycle plus any stall cycles.
REQ-034 data_in=8'h81, shift_amt=7, mode=10 -> data_out=8'h03 after 7 edges; with mode=01 -> 8'hFF; with mode=00 -> 8'h01.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable throughout; in_ready stays 0 even with in_valid=1; the result drains on the first out_ready=1 edge.
REQ-036 Assert rst_n=0 for half a cycle mid-SHIFT (shift_amt=5, after 2 shifts) -> outputs go to reset values immediately, no out_valid for the aborted request; the next request (8'hF0, amt 4, mode 00) yields 8'h0F.
REQ-037 Random regression of 1000 requests over all modes and amounts with random in_valid/out_ready -> every result matches the reference model, with no lost or duplicated results.
